// File: rtl/video_xbar.sv
// N_IN x N_OUT pixel-stream crossbar with frame-boundary source switching.
// Optional: VIDEO_XBAR_FRAMESYNC_EN makes commits wait for the new source's vsync edge.
module video_xbar #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int DW     = 24,
    parameter int SELW   = 1,
    parameter int PORTW  = 1,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [N_IN*DW-1:0]    in_rgb,
    input  logic [N_IN-1:0]       in_de,
    input  logic [N_IN-1:0]       in_hsync,
    input  logic [N_IN-1:0]       in_vsync,
    input  logic [N_IN-1:0]       in_rdy,
    input  logic                  sel_wr,
    input  logic [PORTW-1:0]      sel_port,
    input  logic [SELW-1:0]       sel_src,
    output logic                  sel_err,
    output logic [N_OUT*DW-1:0]   out_rgb,
    output logic [N_OUT-1:0]      out_de,
    output logic [N_OUT-1:0]      out_hsync,
    output logic [N_OUT-1:0]      out_vsync,
    output logic [N_OUT*SELW-1:0] out_src,
    output logic [N_OUT-1:0]      out_pending
);

    localparam int NSRC = 2**SELW;
    localparam logic [PORTW:0] NOUT_L = (PORTW+1)'(N_OUT);
    localparam logic [SELW:0]  NIN_L  = (SELW+1)'(N_IN);

    typedef enum logic {S_IDLE, S_PEND} st_t;

    // Source vectors padded to the full select range so any select value indexes safely.
    logic [DW-1:0]   w_rgb [NSRC];
    logic [NSRC-1:0] w_de, w_hs, w_vs, w_rdy;
`ifdef VIDEO_XBAR_FRAMESYNC_EN
    logic [NSRC-1:0] w_edge;
`endif

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        if (i < N_IN) begin : g_real
            assign w_rgb[i] = in_rgb[i*DW +: DW];
            assign w_de[i]  = in_de[i];
            assign w_hs[i]  = in_hsync[i];
            assign w_vs[i]  = in_vsync[i];
            assign w_rdy[i] = in_rdy[i];
`ifdef VIDEO_XBAR_FRAMESYNC_EN
            logic r_vs_d;
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) r_vs_d <= ~VS_POL;
                else        r_vs_d <= in_vsync[i];
            end
            assign w_edge[i] = (in_vsync[i] == VS_POL) && (r_vs_d != VS_POL);
`endif
        end else begin : g_pad
            assign w_rgb[i] = '0;
            assign w_de[i]  = 1'b0;
            assign w_hs[i]  = 1'b0;
            assign w_vs[i]  = 1'b0;
            assign w_rdy[i] = 1'b0;
`ifdef VIDEO_XBAR_FRAMESYNC_EN
            assign w_edge[i] = 1'b0;
`endif
        end
    end

    logic w_wr_ok;
    logic r_sel_err;

    assign w_wr_ok = sel_wr && ({1'b0, sel_port} < NOUT_L) && ({1'b0, sel_src} < NIN_L);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_sel_err <= 1'b0;
        else        r_sel_err <= sel_wr && !w_wr_ok;
    end
    assign sel_err = r_sel_err;

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        st_t            r_st, w_st_nxt;
        logic [SELW-1:0] r_cur, r_pend, w_sel;
        logic            w_wr_me, w_commit;
        logic [DW-1:0]   r_rgb;
        logic            r_de, r_hs, r_vs;

        assign w_wr_me = w_wr_ok && (sel_port == PORTW'(j));
`ifdef VIDEO_XBAR_FRAMESYNC_EN
        // A dead source is committed at once; waiting for its vsync would stall forever.
        assign w_commit = (r_st == S_PEND) && (w_edge[r_pend] || !w_rdy[r_pend]);
`else
        assign w_commit = (r_st == S_PEND);
`endif
        assign w_sel = w_commit ? r_pend : r_cur;

        always_comb begin
            w_st_nxt = r_st;
            case (r_st)
                S_IDLE:  if (w_wr_me) w_st_nxt = S_PEND;
                S_PEND:  if (w_commit && !w_wr_me) w_st_nxt = S_IDLE;
                default: w_st_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge pclk or negedge rst_n) begin
            if (!rst_n) begin
                r_st   <= S_IDLE;
                r_cur  <= '0;
                r_pend <= '0;
                r_rgb  <= '0;
                r_de   <= 1'b0;
                r_hs   <= ~HS_POL;
                r_vs   <= ~VS_POL;
            end else begin
                r_st <= w_st_nxt;
                if (w_commit) r_cur  <= r_pend;
                if (w_wr_me)  r_pend <= sel_src;
                if (w_rdy[w_sel]) begin
                    r_rgb <= w_rgb[w_sel];
                    r_de  <= w_de[w_sel];
                    r_hs  <= w_hs[w_sel];
                    r_vs  <= w_vs[w_sel];
                end else begin
                    r_rgb <= '0;
                    r_de  <= 1'b0;
                    r_hs  <= ~HS_POL;
                    r_vs  <= ~VS_POL;
                end
            end
        end

        assign out_rgb[j*DW +: DW]     = r_rgb;
        assign out_de[j]               = r_de;
        assign out_hsync[j]            = r_hs;
        assign out_vsync[j]            = r_vs;
        assign out_src[j*SELW +: SELW] = r_cur;
        assign out_pending[j]          = (r_st == S_PEND);
    end

endmodule

// File: tb/tb_video_xbar.sv
// Directed bench for video_xbar: 2 inputs, 2 outputs, hsync active-low, vsync active-high.
module tb_video_xbar;

    localparam int N_IN = 2, N_OUT = 2, DW = 24, SELW = 2, PORTW = 2;

    logic                  pclk, rst_n;
    logic [DW-1:0]         rgb0, rgb1;
    logic [N_IN*DW-1:0]    in_rgb;
    logic [N_IN-1:0]       in_de, in_hsync, in_vsync, in_rdy;
    logic                  sel_wr;
    logic [PORTW-1:0]      sel_port;
    logic [SELW-1:0]       sel_src;
    logic                  sel_err;
    logic [N_OUT*DW-1:0]   out_rgb;
    logic [N_OUT-1:0]      out_de, out_hsync, out_vsync, out_pending;
    logic [N_OUT*SELW-1:0] out_src;

    int n_tot = 0;
    int n_bad = 0;

    assign in_rgb = {rgb1, rgb0};

    video_xbar #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .SELW(SELW), .PORTW(PORTW),
                 .HS_POL(1'b0), .VS_POL(1'b1)) u_dut (
        .pclk(pclk), .rst_n(rst_n), .in_rgb(in_rgb), .in_de(in_de), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_rdy(in_rdy), .sel_wr(sel_wr), .sel_port(sel_port),
        .sel_src(sel_src), .sel_err(sel_err), .out_rgb(out_rgb), .out_de(out_de),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_src(out_src),
        .out_pending(out_pending));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic wr(input logic [PORTW-1:0] p, input logic [SELW-1:0] s);
        sel_wr = 1'b1; sel_port = p; sel_src = s;
    endtask

    initial begin
        rst_n = 1'b0; sel_wr = 1'b0; sel_port = '0; sel_src = '0;
        rgb0 = 24'h5a5a5a; rgb1 = 24'ha5a5a5;
        in_de = 2'b11; in_hsync = 2'b00; in_vsync = 2'b11; in_rdy = 2'b11;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_rgb", out_rgb, 48'h0);
        chk("rst_de", out_de, 2'b00);
        chk("rst_hs", out_hsync, 2'b11);
        chk("rst_vs", out_vsync, 2'b00);
        chk("rst_src", out_src, 4'b0000);
        chk("rst_pend", out_pending, 2'b00);
        chk("rst_err", sel_err, 1'b0);

        // Both outputs mirror input 0 one cycle later
        rst_n = 1'b1;
        rgb0 = 24'h112233; rgb1 = 24'h778899;
        in_de = 2'b01; in_hsync = 2'b10; in_vsync = 2'b00; in_rdy = 2'b11;
        step();
        chk("mir1_rgb", out_rgb, 48'h112233_112233);
        chk("mir1_de", out_de, 2'b11);
        chk("mir1_hs", out_hsync, 2'b00);
        rgb0 = 24'h445566; in_de = 2'b00; in_hsync = 2'b11;
        step();
        chk("mir2_rgb", out_rgb, 48'h445566_445566);
        chk("mir2_de", out_de, 2'b00);
        chk("mir2_hs", out_hsync, 2'b11);

        // Switch output 1 to input 1
        wr(2'd1, 2'd1); rgb0 = 24'h010101;
        step();
        sel_wr = 1'b0;
        chk("sw_pend", out_pending, 2'b10);
        chk("sw_old1", out_rgb[47:24], 24'h010101);
        chk("sw_src0", out_src, 4'b0000);
`ifdef VIDEO_XBAR_FRAMESYNC_EN
        rgb0 = 24'h020202;
        step();
        chk("sw_wait_pend", out_pending, 2'b10);
        chk("sw_wait_rgb", out_rgb[47:24], 24'h020202);
        rgb1 = 24'haabbcc; rgb0 = 24'h030303; in_vsync = 2'b10;
        step();
        chk("sw_vs", out_vsync, 2'b10);
`else
        rgb1 = 24'haabbcc; rgb0 = 24'h030303;
        step();
`endif
        chk("sw_rgb", out_rgb, 48'haabbcc_030303);
        chk("sw_src", out_src, 4'b0100);
        chk("sw_pend_clr", out_pending, 2'b00);
        in_vsync = 2'b00;
        step();

        // Rejected writes leave state untouched
        wr(2'd0, 2'd2);
        step();
        sel_wr = 1'b0;
        chk("err_src", sel_err, 1'b1);
        chk("err_src_pend", out_pending, 2'b00);
        chk("err_src_src", out_src, 4'b0100);
        step();
        chk("err_clr", sel_err, 1'b0);
        wr(2'd3, 2'd0);
        step();
        sel_wr = 1'b0;
        chk("err_port", sel_err, 1'b1);
        chk("err_port_pend", out_pending, 2'b00);
        chk("err_port_src", out_src, 4'b0100);
        step();
        chk("err_clr2", sel_err, 1'b0);

        // Dead input 0 blanks output 0; switching onto it commits immediately
        rgb0 = 24'h123456; in_de = 2'b11; in_hsync = 2'b00; in_rdy = 2'b10;
        step();
        chk("dead_rgb", out_rgb, 48'haabbcc_000000);
        chk("dead_de", out_de, 2'b10);
        chk("dead_hs", out_hsync, 2'b01);
        chk("dead_vs", out_vsync, 2'b00);
        wr(2'd1, 2'd0);
        step();
        sel_wr = 1'b0;
        chk("dead_pend", out_pending, 2'b10);
        step();
        chk("dead_commit_pend", out_pending, 2'b00);
        chk("dead_commit_src", out_src, 4'b0000);
        chk("dead_commit_rgb", out_rgb[47:24], 24'h0);
        chk("dead_commit_de", out_de, 2'b00);
        in_rdy = 2'b11;
        step();

        // Back-to-back writes to output 0
        wr(2'd0, 2'd1);
        step();
        chk("ww_pend1", out_pending, 2'b01);
        wr(2'd0, 2'd0);
        step();
        sel_wr = 1'b0;
`ifdef VIDEO_XBAR_FRAMESYNC_EN
        chk("ww_pend2", out_pending, 2'b01);
        chk("ww_src2", out_src, 4'b0000);
        in_vsync = 2'b10;
        step();
        chk("ww_nocommit_pend", out_pending, 2'b01);
        chk("ww_nocommit_src", out_src, 4'b0000);
        in_vsync = 2'b01; wr(2'd0, 2'd1);
        step();
        sel_wr = 1'b0;
        chk("ww_commit_src", out_src, 4'b0000);
        chk("ww_commit_pend", out_pending, 2'b01);
        in_vsync = 2'b00;
        step();
        chk("ww_hold_pend", out_pending, 2'b01);
        in_vsync = 2'b10;
        step();
        chk("ww_final_src", out_src, 4'b0001);
        chk("ww_final_pend", out_pending, 2'b00);
        chk("ww_final_rgb", out_rgb[23:0], 24'haabbcc);
        chk("ww_final_vs", out_vsync, 2'b01);
        in_vsync = 2'b00;
`else
        chk("ww_src2", out_src, 4'b0001);
        chk("ww_pend2", out_pending, 2'b01);
        step();
        chk("ww_final_src", out_src, 4'b0000);
        chk("ww_final_pend", out_pending, 2'b00);
`endif

        // Asynchronous reset mid-frame drops the queued request
        wr(2'd1, 2'd1);
        step();
        sel_wr = 1'b0;
        chk("ar_pend_pre", out_pending, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pend", out_pending, 2'b00);
        chk("ar_rgb", out_rgb, 48'h0);
        chk("ar_hs", out_hsync, 2'b11);
        chk("ar_vs", out_vsync, 2'b00);
        chk("ar_src", out_src, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/video_xbar.md
# video_xbar

Parametrised pixel-stream crossbar: routes any of `N_IN` decoded video inputs to each of `N_OUT` encoder feeds. All inputs share one pixel clock. Source changes are requested through a small register port and committed at a frame boundary, so outputs do not tear. Unready sources are replaced by clean black with inactive syncs. The block sits between the DVI decoder outputs (after clock-domain alignment) and the `dvi_encoder_top` instances, and is the N×M successor to the fixed 2-in/2-out matrix.

## Interface
Parameters:
- `N_IN`, 2, number of input streams (2..8)
- `N_OUT`, 2, number of output streams (1..8)
- `DW`, 24, pixel width per stream ({blue, green, red})
- `SELW`, 1, select width; 2**SELW >= N_IN
- `PORTW`, 1, output-index width; 2**PORTW >= N_OUT
- `HS_POL`, 1, active level of hsync
- `VS_POL`, 1, active level of vsync

Ports:
- `pclk`  in  1  pixel clock, the only clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_rgb`  in  N_IN*DW  input pixels; stream i is at [i*DW +: DW]
- `in_de`, `in_hsync`, `in_vsync`, `in_rdy`  in  N_IN each  per-input data enable, syncs and decoder ready
- `sel_wr`  in  1  one-cycle select write strobe
- `sel_port`  in  PORTW  output index being written
- `sel_src`  in  SELW  requested source
- `sel_err`  out  1  one-cycle pulse: rejected write
- `out_rgb`  out  N_OUT*DW  output pixels
- `out_de`, `out_hsync`, `out_vsync`  out  N_OUT each  output data enable and syncs
- `out_src`  out  N_OUT*SELW  committed source per output
- `out_pending`  out  N_OUT  a switch is queued

## Operation
- Per-output state:
  - `cur` (committed source)
  - `pend` (queued source)
  - `pv` (pend valid)
- Per-input state: `vs_d`, the registered `in_vsync`. An edge is `in_vsync == VS_POL && vs_d != VS_POL`.
- Write handling:
  - Accepted when `sel_wr` is high, `sel_port < N_OUT` and `sel_src < N_IN`: `pend[sel_port] <= sel_src`, `pv <= 1`. A write overwrites any pending request (last write wins).
  - Otherwise `sel_err` pulses for 1 cycle and no state changes.
- Per-output state machine:
  - IDLE (`pv = 0`) → PENDING on an accepted write.
  - PENDING → IDLE at the commit cycle: `cur <= pend`, `pv <= 0`.
  - Commit condition: vsync edge on input `pend`, or `in_rdy[pend] == 0` (immediate commit; there is no point waiting on a dead source).
- Output mux per output: the mux select is `pend` in the commit cycle, otherwise `cur`.
  - Selected input has `in_rdy = 1`: the output register samples its rgb, de, hsync and vsync.
  - Selected input has `in_rdy = 0`: the output register loads rgb = 0, de = 0, hsync = ~HS_POL, vsync = ~VS_POL.
- Simultaneous commit and accepted write to the same output: the old `pend` commits, the new write is loaded into `pend`, and `pv` stays 1.
- Several outputs may select the same input. Outputs are fully independent.

## Timing
- Reset values:
  - `cur = 0`, `pv = 0`, `pend = 0`, `vs_d = ~VS_POL`
  - `out_rgb = 0`, `out_de = 0`, `out_hsync = ~HS_POL`, `out_vsync = ~VS_POL`
  - `out_src = 0`, `out_pending = 0`, `sel_err = 0`
- Data latency: 1 `pclk` from input to output for every stream, with no bubbles.
- Write latency:
  - `out_pending` rises 1 cycle after `sel_wr`.
  - `out_src` updates 1 cycle after the commit cycle.
  - In the commit cycle the output already carries the new source's vsync-active pixel.
- A write in the same cycle as a vsync edge on the requested source does not commit on that edge; it waits for the next frame.
- Reset asserted mid-frame forces all outputs to the reset values immediately (asynchronously). Queued requests are lost.

## Configuration
- `VIDEO_XBAR_FRAMESYNC_EN`
  - Defined: commit waits for the requested source's vsync edge, as described above.
  - Undefined: the commit condition is `pv` alone. Every accepted write commits on the following cycle (output switches 2 cycles after `sel_wr`), and `vs_d` is not built.

## Test plan
- Reset with `N_IN = 2`, `N_OUT = 2` → all outputs black, de 0, syncs inactive, `out_src = 0`, `sel_err = 0`. After release, output 0 and output 1 mirror input 0 with 1-cycle latency.
- Write `sel_port = 1`, `sel_src = 1` mid-frame with FRAMESYNC on:
  - `out_pending[1] = 1` until input 1's vsync edge.
  - The first output-1 pixel from input 1 is the vsync-active sample.
  - `out_src[1] = 1` on the next cycle.
  - Output 0 is unaffected.
- Write `sel_src = 2` with `N_IN = 2`, or `sel_port = 3` with `N_OUT = 2` → `sel_err` pulses once and state is unchanged.
- Drop `in_rdy[0]` while output 0 shows input 0 → next cycle rgb = 0, de = 0, syncs inactive. A write of `sel_src = 0` while `in_rdy[0] = 0` commits immediately without waiting for vsync.
- Two writes to output 0 (src 1, then src 0) before any vsync edge → only src 0 commits. A write coinciding with a commit leaves `out_pending` at 1.
- FRAMESYNC undefined → every accepted write switches the output exactly 2 cycles after `sel_wr`, regardless of vsync.
